// File: rtl/csr_counter_if.sv
// CSR access port of csr_counter_unit: request, retire/event strobes and combinational response.
interface csr_counter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_HPM    = 4
);
  logic                  csr_valid_i;
  logic [1:0]            csr_op_i;
  logic [11:0]           csr_addr_i;
  logic [DATA_WIDTH-1:0] csr_wdata_i;
  logic                  instret_i;
  logic [NUM_HPM-1:0]    hpm_event_i;
  logic [DATA_WIDTH-1:0] csr_rdata_o;
  logic                  csr_illegal_o;

  modport master (
    output csr_valid_i, csr_op_i, csr_addr_i, csr_wdata_i, instret_i, hpm_event_i,
    input  csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_valid_i, csr_op_i, csr_addr_i, csr_wdata_i, instret_i, hpm_event_i,
    output csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_counter_unit.sv
// CSR/counter file: cycle, time, instret, hpm counters, mcountinhibit, ustatus with RW/RS/RC.
// Optional CSR_SNAPSHOT_EN: a low-half read latches the high half for a coherent later high read.
module csr_cnt_slice #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_inc,
  input  logic                  i_wr_lo,
  input  logic                  i_wr_hi,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [CNT_WIDTH-1:0]  o_cnt
);
  localparam int HW = CNT_WIDTH - DATA_WIDTH;

  logic [CNT_WIDTH-1:0] r_cnt;

  // A write to either half wins over the increment; the other half holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_cnt <= '0;
    else if (i_wr_lo) r_cnt[DATA_WIDTH-1:0] <= i_wdata;
    else if (i_wr_hi) r_cnt[CNT_WIDTH-1:DATA_WIDTH] <= i_wdata[HW-1:0];
    else if (i_inc)   r_cnt <= r_cnt + CNT_WIDTH'(1);
  end

  assign o_cnt = r_cnt;
endmodule

module csr_counter_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_HPM    = 4,
  parameter int TIME_DIV   = 1
) (
  input logic         clk,
  input logic         rst,
  csr_counter_if.slave bus
);
  localparam int NCNT = NUM_HPM + 3;
  localparam int PW   = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  // Inhibit bits exist for CY, IR and each HPM; bit 1 (time) is never inhibitable.
  localparam logic [NCNT-1:0] INH_MASK = {{(NCNT-2){1'b1}}, 2'b01};

  typedef struct packed {
    logic       ustat;
    logic       inh;
    logic       ro;
    logic       mc;
    logic       hi;
    logic [4:0] idx;
  } csr_dec_t;

  csr_dec_t                        w_dec;
  logic                            w_in_rng;
  logic                            w_mapped;
  logic                            w_wr_req;
  logic                            w_illegal;
  logic                            w_legal;
  logic                            w_we;
  logic                            w_tick;
  logic [CNT_WIDTH-1:0]            w_cnt_sel;
  logic [DATA_WIDTH-1:0]           w_live;
  logic [DATA_WIDTH-1:0]           w_rd;
  logic [DATA_WIDTH-1:0]           w_new;
  logic [NCNT-1:0][CNT_WIDTH-1:0]  w_cnt;
  logic [NCNT-1:0]                 w_inc;
  logic [NCNT-1:0]                 w_wr_lo;
  logic [NCNT-1:0]                 w_wr_hi;

  logic [NCNT-1:0]                 r_inhibit;
  logic [DATA_WIDTH-1:0]           r_ustatus;
  logic [PW-1:0]                   r_presc;

  // Counter index is addr[4:0] in every counter window (0xC0x, 0xC8x, 0xB0x, 0xB8x).
  always_comb begin
    w_dec       = '0;
    w_dec.idx   = bus.csr_addr_i[4:0];
    w_dec.hi    = bus.csr_addr_i[7];
    w_in_rng    = (bus.csr_addr_i[6:5] == 2'b00) &&
                  ({1'b0, bus.csr_addr_i[4:0]} < 6'(NCNT));
    w_dec.ustat = (bus.csr_addr_i == 12'h000);
    w_dec.inh   = (bus.csr_addr_i == 12'h320);
    w_dec.ro    = (bus.csr_addr_i[11:8] == 4'hC) && w_in_rng;
    w_dec.mc    = (bus.csr_addr_i[11:8] == 4'hB) && w_in_rng &&
                  (bus.csr_addr_i[4:0] != 5'd1);
  end

  assign w_mapped  = w_dec.ustat | w_dec.inh | w_dec.ro | w_dec.mc;
  assign w_wr_req  = (bus.csr_op_i == OP_RW) ||
                     (((bus.csr_op_i == OP_RS) || (bus.csr_op_i == OP_RC)) &&
                      (|bus.csr_wdata_i));
  assign w_illegal = bus.csr_valid_i && (!w_mapped || (w_dec.ro && w_wr_req));
  assign w_legal   = bus.csr_valid_i && !w_illegal;
  assign w_we      = w_legal && w_wr_req;

  always_comb begin
    w_cnt_sel = '0;
    for (int i = 0; i < NCNT; i++)
      if (w_dec.idx == 5'(i)) w_cnt_sel = w_cnt[i];
  end

  always_comb begin
    w_live = '0;
    if (w_dec.ustat)             w_live = r_ustatus;
    else if (w_dec.inh)          w_live = DATA_WIDTH'(r_inhibit);
    else if (w_dec.ro || w_dec.mc)
      w_live = w_dec.hi ? DATA_WIDTH'(w_cnt_sel[CNT_WIDTH-1:DATA_WIDTH])
                        : w_cnt_sel[DATA_WIDTH-1:0];
  end

  // Read-modify-write always works on the live value, never on a stale snapshot.
  always_comb begin
    case (bus.csr_op_i)
      OP_RW:   w_new = bus.csr_wdata_i;
      OP_RS:   w_new = w_live | bus.csr_wdata_i;
      OP_RC:   w_new = w_live & ~bus.csr_wdata_i;
      default: w_new = w_live;
    endcase
  end

`ifdef CSR_SNAPSHOT_EN
  logic                  r_snap_vld;
  logic [4:0]            r_snap_tag;
  logic [DATA_WIDTH-1:0] r_snap;
  logic                  w_snap_hit;

  assign w_snap_hit = r_snap_vld && (r_snap_tag == w_dec.idx) &&
                      (w_dec.ro || w_dec.mc) && w_dec.hi;

  // Capture the pre-update high half so it pairs with the low half just returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap_vld <= 1'b0;
      r_snap_tag <= '0;
      r_snap     <= '0;
    end else if (w_legal && (w_dec.ro || w_dec.mc)) begin
      if (!w_dec.hi) begin
        r_snap_vld <= 1'b1;
        r_snap_tag <= w_dec.idx;
        r_snap     <= DATA_WIDTH'(w_cnt_sel[CNT_WIDTH-1:DATA_WIDTH]);
      end else if (w_snap_hit) begin
        r_snap_vld <= 1'b0;
      end
    end
  end

  assign w_rd = w_snap_hit ? r_snap : w_live;
`else
  assign w_rd = w_live;
`endif

  assign bus.csr_rdata_o   = w_legal ? w_rd : '0;
  assign bus.csr_illegal_o = w_illegal;

  assign w_tick = (r_presc == PW'(TIME_DIV - 1));

  // Inhibit updates land next cycle, so this cycle's increments see the old mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ustatus <= '0;
      r_inhibit <= '0;
      r_presc   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_we && w_dec.ustat) r_ustatus <= w_new;
      if (w_we && w_dec.inh)   r_inhibit <= w_new[NCNT-1:0] & INH_MASK;
    end
  end

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    assign w_wr_lo[g] = w_we && w_dec.mc && !w_dec.hi && (w_dec.idx == 5'(g));
    assign w_wr_hi[g] = w_we && w_dec.mc &&  w_dec.hi && (w_dec.idx == 5'(g));

    if (g == 0) begin : g_cy
      assign w_inc[g] = !r_inhibit[0];
    end else if (g == 1) begin : g_tm
      assign w_inc[g] = w_tick;
    end else if (g == 2) begin : g_ir
      assign w_inc[g] = bus.instret_i && !r_inhibit[2];
    end else begin : g_hpm
      assign w_inc[g] = bus.hpm_event_i[g-3] && !r_inhibit[g];
    end

    csr_cnt_slice #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_slice (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_inc[g]),
      .i_wr_lo (w_wr_lo[g]),
      .i_wr_hi (w_wr_hi[g]),
      .i_wdata (w_new),
      .o_cnt   (w_cnt[g])
    );
  end
endmodule

// File: tb/tb_csr_counter_unit.sv
// Bench for csr_counter_unit: directed scenarios plus random traffic against a behavioural model.
module tb_csr_counter_unit;
  localparam int DW = 32;
  localparam int CW = 64;
  localparam int NH = 4;
  localparam int TD = 3;
  localparam int NC = NH + 3;
`ifdef CSR_SNAPSHOT_EN
  localparam logic [31:0] T6_HI = 32'd1;
`else
  localparam logic [31:0] T6_HI = 32'd2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  csr_counter_if #(.DATA_WIDTH(DW), .NUM_HPM(NH)) bus ();

  csr_counter_unit #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .NUM_HPM    (NH),
    .TIME_DIV   (TD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: counters as 64-bit integers, CSRs as plain words.
  logic [63:0] m_cnt [NC];
  logic [31:0] m_ust, m_inh, m_snap;
  int          m_pre, m_tag;
  bit          m_sv;

  // Result of evaluating the current access.
  logic [31:0] e_rd, e_new, e_live;
  bit          e_ill, e_wr, e_leg, e_hi;
  int          e_kind, e_id;

  function automatic logic [31:0] inh_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < NC; i++) if (i != 1) m[i] = 1'b1;
    return m;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NC; i++) m_cnt[i] = '0;
    m_ust = '0; m_inh = '0; m_snap = '0; m_pre = 0; m_tag = 0; m_sv = 0;
  endtask

  // kind: 0 unmapped, 1 ustatus, 2 mcountinhibit, 3 read-only counter, 4 machine counter
  task automatic decode(input logic [11:0] a, output int kind, output int id, output bit hi);
    int ai = int'(a);
    kind = 0; id = 0; hi = 0;
    if (ai == 'h000) kind = 1;
    else if (ai == 'h320) kind = 2;
    else if (ai >= 'hC00 && ai < 'hC00 + NC) begin kind = 3; id = ai - 'hC00; end
    else if (ai >= 'hC80 && ai < 'hC80 + NC) begin kind = 3; id = ai - 'hC80; hi = 1; end
    else if (ai >= 'hB00 && ai < 'hB00 + NC && ai != 'hB01) begin kind = 4; id = ai - 'hB00; end
    else if (ai >= 'hB80 && ai < 'hB80 + NC && ai != 'hB81) begin kind = 4; id = ai - 'hB80; hi = 1; end
  endtask

  task automatic m_eval(input bit v, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] wd);
    bit          wreq;
    logic [31:0] rdv;
    decode(a, e_kind, e_id, e_hi);
    wreq   = (op == 2'd1) || (op != 2'd0 && wd != 0);
    e_ill  = v && (e_kind == 0 || (e_kind == 3 && wreq));
    e_leg  = v && !e_ill;
    e_live = '0;
    case (e_kind)
      1: e_live = m_ust;
      2: e_live = m_inh;
      3, 4: e_live = e_hi ? m_cnt[e_id][63:32] : m_cnt[e_id][31:0];
      default: e_live = '0;
    endcase
    rdv = e_live;
`ifdef CSR_SNAPSHOT_EN
    if (e_kind >= 3 && e_hi && m_sv && m_tag == e_id) rdv = m_snap;
`endif
    e_rd  = e_leg ? rdv : 32'd0;
    e_wr  = e_leg && wreq;
    e_new = (op == 2'd1) ? wd : (op == 2'd2) ? (e_live | wd) : (e_live & ~wd);
  endtask

  task automatic m_step(input bit ir, input logic [NH-1:0] ev);
    bit inc;
`ifdef CSR_SNAPSHOT_EN
    if (e_leg && e_kind >= 3) begin
      if (!e_hi) begin m_sv = 1; m_tag = e_id; m_snap = m_cnt[e_id][63:32]; end
      else if (m_sv && m_tag == e_id) m_sv = 0;
    end
`endif
    for (int i = 0; i < NC; i++) begin
      if (i == 0)      inc = !m_inh[0];
      else if (i == 1) inc = (m_pre == TD - 1);
      else if (i == 2) inc = ir && !m_inh[2];
      else             inc = ev[i-3] && !m_inh[i];
      if (e_wr && e_kind == 4 && e_id == i) begin
        if (e_hi) m_cnt[i][63:32] = e_new;
        else      m_cnt[i][31:0]  = e_new;
      end else if (inc) begin
        m_cnt[i] = m_cnt[i] + 64'd1;
      end
    end
    m_pre = (m_pre == TD - 1) ? 0 : m_pre + 1;
    if (e_wr && e_kind == 1) m_ust = e_new;
    if (e_wr && e_kind == 2) m_inh = e_new & inh_mask();
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd, input bit ir, input logic [NH-1:0] ev);
    bus.csr_valid_i = v;
    bus.csr_op_i    = op;
    bus.csr_addr_i  = a;
    bus.csr_wdata_i = wd;
    bus.instret_i   = ir;
    bus.hpm_event_i = ev;
  endtask

  // One clock of traffic; starts and ends just after a falling edge.
  task automatic cyc(input string tag, input bit v, input logic [1:0] op,
                     input logic [11:0] a, input logic [31:0] wd, input bit ir,
                     input logic [NH-1:0] ev, input bit kc, input logic [31:0] kv);
    drive(v, op, a, wd, ir, ev);
    m_eval(v, op, a, wd);
    #1;
    chk({tag, "_rd"}, 64'(bus.csr_rdata_o), 64'(e_rd));
    chk({tag, "_ill"}, 64'(bus.csr_illegal_o), 64'(e_ill));
    if (kc) chk({tag, "_k"}, 64'(bus.csr_rdata_o), 64'(kv));
    @(posedge clk);
    m_step(ir, ev);
    @(negedge clk);
  endtask

  task automatic do_rst(input bit v, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] wd);
    drive(v, op, a, wd, 1'b1, '1);
    rst = 1'b1;
    m_reset();
    m_eval(v, op, a, wd);
    #1;
    chk("rst_rd", 64'(bus.csr_rdata_o), 64'(e_rd));
    chk("rst_ill", 64'(bus.csr_illegal_o), 64'(e_ill));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [11:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return 12'h000;
      1:       return 12'h320;
      2:       return 12'hC00 + 12'($urandom_range(0, 7));
      3:       return 12'hC80 + 12'($urandom_range(0, 7));
      4, 5:    return 12'hB00 + 12'($urandom_range(0, 7));
      6, 7:    return 12'hB80 + 12'($urandom_range(0, 7));
      8:       return 12'($urandom);
      default: return 12'hC00 + 12'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 2'd0, 12'h000, 32'h0, 1'b0, '0);
    m_reset();
    @(negedge clk);
    do_rst(1'b1, 2'd0, 12'hC00, 32'h0);

    // Free-running cycle counter after reset release.
    for (int i = 0; i < 10; i++) cyc("t1_idle", 0, 2'd0, 12'h000, 32'h0, 0, '0, 0, 0);
    cyc("t1_lo", 1, 2'd0, 12'hC00, 32'h0, 0, '0, 1, 32'd10);
    cyc("t1_hi", 1, 2'd0, 12'hC80, 32'h0, 0, '0, 1, 32'd0);

    // Low-to-high carry.
    cyc("t2_whi", 1, 2'd1, 12'hB80, 32'h0, 0, '0, 0, 0);
    cyc("t2_wlo", 1, 2'd1, 12'hB00, 32'hFFFF_FFFF, 0, '0, 0, 0);
    cyc("t2_idle", 0, 2'd0, 12'h000, 32'h0, 0, '0, 0, 0);
    cyc("t2_lo", 1, 2'd0, 12'hC00, 32'h0, 0, '0, 1, 32'd0);
    cyc("t2_hi", 1, 2'd0, 12'hC80, 32'h0, 0, '0, 1, 32'd1);

    // Inhibit cycle and instret, then resume.
    cyc("t3_inh", 1, 2'd2, 12'h320, 32'h5, 1, '1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc("t3_cy", 1, 2'd0, 12'hC00, 32'h0, 1, '1, 0, 0);
      cyc("t3_ir", 1, 2'd0, 12'hC02, 32'h0, 1, '0, 0, 0);
    end
    cyc("t3_rd_inh", 1, 2'd0, 12'h320, 32'h0, 0, '0, 1, 32'h5);
    cyc("t3_clr", 1, 2'd3, 12'h320, 32'h5, 1, '0, 0, 0);
    cyc("t3_ir2", 1, 2'd0, 12'hC02, 32'h0, 1, '0, 0, 0);

    // Illegal accesses and the zero-operand exception.
    cyc("t4_rwc00", 1, 2'd1, 12'hC00, 32'h123, 0, '0, 1, 32'd0);
    cyc("t4_cy", 1, 2'd0, 12'hC00, 32'h0, 0, '0, 0, 0);
    cyc("t4_7ff", 1, 2'd0, 12'h7FF, 32'h0, 0, '0, 1, 32'd0);
    cyc("t4_rs0", 1, 2'd2, 12'hC00, 32'h0, 0, '0, 0, 0);
    cyc("t4_hpmk", 1, 2'd0, 12'hC83 + 12'(NH), 32'h0, 0, '0, 1, 32'd0);
    cyc("t4_time", 1, 2'd1, 12'hB01, 32'h1, 0, '0, 1, 32'd0);

    // ustatus read-modify-write.
    cyc("t5_w", 1, 2'd1, 12'h000, 32'hF0F0, 0, '0, 0, 0);
    cyc("t5_rc", 1, 2'd3, 12'h000, 32'h00F0, 0, '0, 1, 32'hF0F0);
    cyc("t5_rd", 1, 2'd0, 12'h000, 32'h0, 0, '0, 1, 32'hF000);

    // Coherent high-half read.
    cyc("t6_whi", 1, 2'd1, 12'hB80, 32'h1, 0, '0, 0, 0);
    cyc("t6_wlo", 1, 2'd1, 12'hB00, 32'hFFFF_FFFD, 0, '0, 0, 0);
    cyc("t6_lo", 1, 2'd0, 12'hB00, 32'h0, 0, '0, 1, 32'hFFFF_FFFD);
    for (int i = 0; i < 3; i++) cyc("t6_idle", 0, 2'd0, 12'h000, 32'h0, 0, '0, 0, 0);
    cyc("t6_hi", 1, 2'd0, 12'hB80, 32'h0, 0, '0, 1, T6_HI);

    // Random traffic with occasional mid-stream resets carrying a pending write.
    for (int n = 0; n < 2000; n++) begin
      if (n % 400 == 399)
        do_rst(1'b1, 2'd1, 12'hB00 + 12'($urandom_range(0, 7)), $urandom);
      else
        cyc("rnd", ($urandom_range(0, 9) < 8), 2'($urandom), rnd_addr(), rnd_data(),
            1'($urandom), NH'($urandom), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
